// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module      : branch_history_table
//  Description : Direct-mapped branch history / target table. Combinational
//                fetch-side lookup (taken prediction + target) and registered
//                EX-side training with 2-bit saturating counters, entry
//                allocation, prediction verdict and branch statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_history_table #(
    parameter int ENTRIES = 16,
    parameter int WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] pc,
    output logic              pred_control,
    output logic [WORD_W-1:0] pred_branch,
    input  logic              res_valid,
    input  logic [WORD_W-1:0] res_pc,
    input  logic              res_taken,
    input  logic [WORD_W-1:0] res_target,
    input  logic              res_pred_taken,
    input  logic [WORD_W-1:0] res_pred_target,
    output logic              pred_success,
    output logic              pred_fail,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);

    localparam int          c_IDX_W    = $clog2(ENTRIES);
    localparam int          c_TAG_W    = WORD_W - c_IDX_W - 2;
    localparam logic [1:0]  c_CTR_INIT = 2'b01;
    localparam logic [1:0]  c_CTR_ALOC = 2'b10;
    localparam logic [1:0]  c_CTR_MAX  = 2'b11;
    localparam logic [1:0]  c_CTR_MIN  = 2'b00;
    localparam logic [31:0] c_STAT_MAX = 32'hFFFF_FFFF;

    // Table state, held entirely in flops
    logic                r_valid  [ENTRIES];
    logic [c_TAG_W-1:0]  r_tag    [ENTRIES];
    logic [WORD_W-1:0]   r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [31:0]         r_branches;
    logic [31:0]         r_mispredicts;

    logic [c_IDX_W-1:0]  w_look_idx;
    logic [c_TAG_W-1:0]  w_look_tag;
    logic                w_look_hit;
    logic [c_IDX_W-1:0]  w_res_idx;
    logic [c_TAG_W-1:0]  w_res_tag;
    logic                w_res_hit;
    logic                w_mispredict;
    logic                w_unused_ok;

    assign w_look_idx = pc[c_IDX_W+1:2];
    assign w_look_tag = pc[WORD_W-1:c_IDX_W+2];
    assign w_res_idx  = res_pc[c_IDX_W+1:2];
    assign w_res_tag  = res_pc[WORD_W-1:c_IDX_W+2];

    // Byte offset bits of both PCs carry no information for word-aligned fetch
    assign w_unused_ok = ^{pc[1:0], res_pc[1:0]};

    // Fetch lookup reads the pre-update table contents (no write bypass)
    always_comb begin
        w_look_hit   = r_valid[w_look_idx] && (r_tag[w_look_idx] == w_look_tag);
        pred_control = w_look_hit && r_ctr[w_look_idx][1];
        pred_branch  = w_look_hit ? r_target[w_look_idx] : '0;
    end

    // Resolve verdict: wrong direction, or right "taken" to the wrong target
    always_comb begin
        w_res_hit    = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
        w_mispredict = res_valid &&
                       ((res_taken != res_pred_taken) ||
                        (res_taken && res_pred_taken && (res_target != res_pred_target)));
        pred_fail    = w_mispredict && !RST;
        pred_success = res_valid && !w_mispredict && !RST;
    end

    assign stat_branches    = r_branches;
    assign stat_mispredicts = r_mispredicts;

    // Training, allocation and statistics; reset has priority over a resolve
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_INIT;
            end
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else if (res_valid) begin
            if (r_branches != c_STAT_MAX) begin
                r_branches <= r_branches + 32'd1;
            end
            if (w_mispredict && (r_mispredicts != c_STAT_MAX)) begin
                r_mispredicts <= r_mispredicts + 32'd1;
            end
            if (w_res_hit) begin
                if (res_taken) begin
                    if (r_ctr[w_res_idx] != c_CTR_MAX) begin
                        r_ctr[w_res_idx] <= r_ctr[w_res_idx] + 2'd1;
                    end
                    r_target[w_res_idx] <= res_target;
                end else if (r_ctr[w_res_idx] != c_CTR_MIN) begin
                    r_ctr[w_res_idx] <= r_ctr[w_res_idx] - 2'd1;
                end
            end else if (res_taken) begin
                r_valid[w_res_idx]  <= 1'b1;
                r_tag[w_res_idx]    <= w_res_tag;
                r_target[w_res_idx] <= res_target;
                r_ctr[w_res_idx]    <= c_CTR_ALOC;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_history_table
//  Description : Scoreboard bench for branch_history_table. The driver
//                computes expected responses from a table model and queues
//                them; a negedge monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_history_table;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] pc = '0;
    logic        pred_control;
    logic [31:0] pred_branch;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pred_target = '0;
    logic        pred_success;
    logic        pred_fail;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_history_table #(.ENTRIES(16), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .pc(pc),
        .pred_control(pred_control), .pred_branch(pred_branch),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .res_target(res_target), .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target),
        .pred_success(pred_success), .pred_fail(pred_fail),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    // Reference model: one record per table slot, counter kept as an integer 0..3
    typedef struct {
        bit          v;
        logic [25:0] tag;
        logic [31:0] tgt;
        int          cnt;
    } ent_t;

    typedef struct {
        bit          chk_state;
        bit          ctl;
        logic [31:0] br;
        bit          succ;
        bit          fail;
        logic [31:0] nbr;
        logic [31:0] nmp;
    } exp_t;

    ent_t    model [16];
    longint  m_br = 0;
    longint  m_mp = 0;
    bit      m_init = 1'b0;
    exp_t    sb_q [$];
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive, queue the expected response, advance the model
    task automatic step(input bit rst, input logic [31:0] a, input bit rv,
                        input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                        input bit rpt, input logic [31:0] rptgt);
        exp_t e;
        int   li, ri;
        bit   lhit, rhit, fail;
        @(posedge CLK);
        #1;
        RST       = rst;
        pc        = a;
        res_valid = rv;
        if (rv) begin
            res_pc = rpc; res_taken = rt; res_target = rtgt;
            res_pred_taken = rpt; res_pred_target = rptgt;
        end else begin
            res_pc = 'x; res_taken = 1'bx; res_target = 'x;
            res_pred_taken = 1'bx; res_pred_target = 'x;
        end

        li   = int'(a[5:2]);
        lhit = model[li].v && (model[li].tag == a[31:6]);
        fail = rv && ((rt != rpt) || (rt && rpt && (rtgt != rptgt)));
        e.chk_state = m_init;
        e.ctl  = lhit && (model[li].cnt >= 2);
        e.br   = lhit ? model[li].tgt : 32'h0;
        e.fail = !rst && fail;
        e.succ = !rst && rv && !fail;
        e.nbr  = m_br[31:0];
        e.nmp  = m_mp[31:0];
        sb_q.push_back(e);

        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                model[i].v = 1'b0; model[i].tag = '0; model[i].tgt = '0; model[i].cnt = 1;
            end
            m_br = 0; m_mp = 0; m_init = 1'b1;
        end else if (rv) begin
            m_br = (m_br + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_br + 1;
            if (fail) m_mp = (m_mp + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mp + 1;
            ri   = int'(rpc[5:2]);
            rhit = model[ri].v && (model[ri].tag == rpc[31:6]);
            if (rhit && rt) begin
                model[ri].cnt = (model[ri].cnt < 3) ? model[ri].cnt + 1 : 3;
                model[ri].tgt = rtgt;
            end else if (rhit) begin
                model[ri].cnt = (model[ri].cnt > 0) ? model[ri].cnt - 1 : 0;
            end else if (rt) begin
                model[ri].v = 1'b1; model[ri].tag = rpc[31:6];
                model[ri].tgt = rtgt; model[ri].cnt = 2;
            end
        end
    endtask

    task automatic idle(input logic [31:0] a);
        step(1'b0, a, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic [31:0] a, input logic [31:0] rpc, input bit rt,
                           input logic [31:0] rtgt, input bit rpt, input logic [31:0] rptgt);
        step(1'b0, a, 1'b1, rpc, rt, rtgt, rpt, rptgt);
    endtask

    // Monitor: outputs are always presented; compare each cycle's queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pred_success", {31'h0, pred_success}, {31'h0, e.succ});
                check("pred_fail",    {31'h0, pred_fail},    {31'h0, e.fail});
                if (e.chk_state) begin
                    check("pred_control",     {31'h0, pred_control}, {31'h0, e.ctl});
                    check("pred_branch",      pred_branch,      e.br);
                    check("stat_branches",    stat_branches,    e.nbr);
                    check("stat_mispredicts", stat_mispredicts, e.nmp);
                end
            end
        end
    end

    initial begin
        logic [31:0] a, r, t;
        bit          pt;
        int          ri;
        // Reset and empty-table lookup
        step(1'b1, 32'h40, 1'b0, 0, 0, 0, 0, 0);
        step(1'b1, 32'h40, 1'b0, 0, 0, 0, 0, 0);
        idle(32'h40);
        // Allocation on a mispredicted taken branch
        resolve(32'h40, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        idle(32'h40);
        // Counter saturation and decay
        repeat (3) resolve(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        resolve(32'h40, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        idle(32'h40);
        resolve(32'h40, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        idle(32'h40);
        // Alias replacement at the same index
        resolve(32'h440, 32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
        idle(32'h40);
        idle(32'h440);
        // Same-cycle lookup and training: pre-update contents first
        resolve(32'h80, 32'h80, 1'b1, 32'h180, 1'b0, 32'h0);
        idle(32'h80);
        // Target mismatch with correct direction
        resolve(32'h440, 32'h440, 1'b1, 32'h304, 1'b1, 32'h300);
        idle(32'h440);
        // Reset colliding with a resolve: reset wins
        step(1'b1, 32'h440, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        idle(32'h500);
        idle(32'h440);

        // Randomized traffic over a few indices and tags to force hits and aliases
        for (int n = 0; n < 600; n++) begin
            a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            r = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            t = {$urandom_range(0, 3), 2'b00} + 32'h1000;
            ri = int'(r[5:2]);
            if ($urandom_range(0, 1) == 0) begin
                pt = model[ri].v && (model[ri].tag == r[31:6]) && (model[ri].cnt >= 2);
                step(($urandom_range(0, 99) == 0), a, ($urandom_range(0, 3) != 0), r,
                     bit'($urandom_range(0, 1)), t, pt,
                     (model[ri].v && (model[ri].tag == r[31:6])) ? model[ri].tgt : 32'h0);
            end else begin
                step(($urandom_range(0, 99) == 0), a, ($urandom_range(0, 3) != 0), r,
                     bit'($urandom_range(0, 1)), t, bit'($urandom_range(0, 1)),
                     {$urandom_range(0, 3), 2'b00} + 32'h1000);
            end
        end

        idle(32'h0);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
